// File: rtl/fir_pkg.sv
// Shared types and helpers for the serial-MAC FIR filter.
package fir_pkg;

  typedef enum logic [1:0] {IDLE, MAC, HOLD} state_t;

  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Clamp to an out_w-bit signed range; the caller keeps the low out_w bits, so saturate=0 wraps.
  function automatic logic signed [63:0] sat_value(input logic signed [63:0] v, input int out_w,
                                                   input logic saturate);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    sat_value = v;
    if (saturate && out_w < 64) begin
      if (v > hi) sat_value = hi;
      else if (v < lo) sat_value = lo;
    end
  endfunction

  function automatic logic sat_hit(input logic signed [63:0] v, input int out_w,
                                   input logic saturate);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    return saturate && (out_w < 64) && ((v > hi) || (v < lo));
  endfunction

endpackage

// File: rtl/fir_scale_sat.sv
// Final-sum scaling: floor shift, then clamp or wrap to the output width.
module fir_scale_sat
  import fir_pkg::*;
#(
  parameter int ACC_W    = 27,
  parameter int OUT_W    = 32,
  parameter int SHIFT    = 0,
  parameter int SATURATE = 1
) (
  input  logic [ACC_W-1:0] acc,
  output logic [OUT_W-1:0] result,
  output logic             clamped
);

  logic signed [ACC_W-1:0] shifted;
  logic signed [63:0]      wide;

  always_comb begin
    shifted = $signed(acc) >>> SHIFT;
    wide    = 64'(shifted);
    result  = OUT_W'(sat_value(wide, OUT_W, SATURATE != 0));
    clamped = sat_hit(wide, OUT_W, SATURATE != 0);
  end

endmodule

// File: rtl/fir_mac_serial.sv
// N-tap FIR with programmable coefficients, evaluated one tap per cycle on a single MAC.
module fir_mac_serial
  import fir_pkg::*;
#(
  parameter int NTAPS    = 8,
  parameter int DATA_W   = 16,
  parameter int COEF_W   = 8,
  parameter int OUT_W    = 32,
  parameter int ACC_W    = DATA_W + COEF_W + clog2(NTAPS),
  parameter int SHIFT    = 0,
  parameter int SATURATE = 1,
  parameter int COEF_RST = 16
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      ENABLE,
  input  logic [DATA_W-1:0]         input_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [OUT_W-1:0]          output_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      sat_flag,
  output logic [DATA_W-1:0]         sampleT,
  input  logic                      coef_we,
  input  logic [clog2(NTAPS)-1:0]   coef_addr,
  input  logic [COEF_W-1:0]         coef_data,
  output logic                      coef_rej
);

  localparam int AW = clog2(NTAPS);

  state_t state, state_nxt;

  logic signed [DATA_W-1:0]        samples [NTAPS];
  logic signed [COEF_W-1:0]        coefs   [NTAPS];
  logic signed [ACC_W-1:0]         acc, acc_sum;
  logic signed [DATA_W+COEF_W-1:0] prod;
  logic [AW-1:0]                   k;
  logic [OUT_W-1:0]                scaled;
  logic                            clamped;
  logic                            accept, coef_ok, last_tap;

  assign accept   = in_valid && in_ready;
  assign last_tap = (int'(k) == NTAPS - 1);
  assign coef_ok  = (state == IDLE) && ENABLE && (int'(coef_addr) < NTAPS);
  assign prod     = coefs[k] * samples[k];
  assign acc_sum  = acc + ACC_W'(prod);
  assign sampleT  = samples[0];

  fir_scale_sat #(
    .ACC_W    (ACC_W),
    .OUT_W    (OUT_W),
    .SHIFT    (SHIFT),
    .SATURATE (SATURATE)
  ) u_scale (
    .acc     (acc_sum),
    .result  (scaled),
    .clamped (clamped)
  );

  always_ff @(posedge CLK) begin
    if (!RST) state <= IDLE;
    else      state <= state_nxt;
  end

  // With ENABLE low no transition fires, so the FSM holds its state.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = ENABLE && RST;
        if (in_valid && ENABLE && RST) state_nxt = MAC;
      end
      MAC: begin
        if (ENABLE && last_tap) state_nxt = HOLD;
      end
      HOLD: begin
        out_valid = ENABLE;
        if (ENABLE && out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A coefficient write sharing the accept edge is in place before the first product.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      acc         <= '0;
      k           <= '0;
      output_data <= '0;
      sat_flag    <= 1'b0;
      coef_rej    <= 1'b0;
      for (int i = 0; i < NTAPS; i++) begin
        samples[i] <= '0;
        coefs[i]   <= COEF_W'(COEF_RST);
      end
    end else begin
      coef_rej <= coef_we && !coef_ok;
      if (coef_we && coef_ok) coefs[coef_addr] <= coef_data;
      if (accept) begin
        samples[0] <= input_data;
        for (int i = 1; i < NTAPS; i++) samples[i] <= samples[i-1];
        acc <= '0;
        k   <= '0;
      end else if (ENABLE && state == MAC) begin
        acc <= acc_sum;
        k   <= k + 1'b1;
        if (last_tap) begin
          output_data <= scaled;
          sat_flag    <= clamped;
        end
      end
    end
  end

endmodule

// File: tb/tb_fir_mac_serial.sv
// Directed bench: a 32-bit and a 16-bit output instance share all stimulus and run in lockstep.
module tb_fir_mac_serial;

  logic        CLK = 1'b0, RST = 1'b0, ENABLE = 1'b1;
  logic        in_valid = 1'b0, out_ready = 1'b1, coef_we = 1'b0;
  logic [15:0] input_data = '0;
  logic [2:0]  coef_addr = '0;
  logic [7:0]  coef_data = '0;

  logic        in_ready, out_valid, sat_flag, coef_rej;
  logic [31:0] output_data;
  logic [15:0] sampleT;
  logic        in_ready2, out_valid2, sat_flag2, coef_rej2;
  logic [15:0] output_data2, sampleT2;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  fir_mac_serial dut (
    .CLK(CLK), .RST(RST), .ENABLE(ENABLE),
    .input_data(input_data), .in_valid(in_valid), .in_ready(in_ready),
    .output_data(output_data), .out_valid(out_valid), .out_ready(out_ready),
    .sat_flag(sat_flag), .sampleT(sampleT),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .coef_rej(coef_rej)
  );

  fir_mac_serial #(.OUT_W(16)) dut16 (
    .CLK(CLK), .RST(RST), .ENABLE(ENABLE),
    .input_data(input_data), .in_valid(in_valid), .in_ready(in_ready2),
    .output_data(output_data2), .out_valid(out_valid2), .out_ready(out_ready),
    .sat_flag(sat_flag2), .sampleT(sampleT2),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .coef_rej(coef_rej2)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b0; ENABLE = 1'b1; in_valid = 1'b0; coef_we = 1'b0; out_ready = 1'b1;
    tick();
    RST = 1'b1;
    #1;
  endtask

  task automatic write_coef(input int a, input int d);
    coef_we = 1'b1; coef_addr = 3'(a); coef_data = 8'(d);
    tick();
    coef_we = 1'b0;
  endtask

  // Offers one sample, waits for its result, captures both instances, then completes the transfer.
  task automatic run_sample(input int x, output logic [31:0] y1, output logic f1,
                            output logic [15:0] y2, output logic f2, output int lat);
    int guard;
    input_data = 16'(x); in_valid = 1'b1; guard = 0;
    while (!in_ready && guard < 50) begin tick(); guard++; end
    if (!in_ready) begin
      checks++; errors++;
      $display("[TB] FAIL accept_timeout: in_ready=%0b required 1", in_ready);
    end
    tick();
    in_valid = 1'b0; lat = 0;
    while (!out_valid && lat < 50) begin tick(); lat++; end
    if (!out_valid) begin
      checks++; errors++;
      $display("[TB] FAIL result_timeout: out_valid=%0b required 1", out_valid);
    end
    y1 = output_data; f1 = sat_flag; y2 = output_data2; f2 = sat_flag2;
    tick();
  endtask

  task automatic test_reset();
    RST = 1'b0; ENABLE = 1'b1; in_valid = 1'b1; input_data = 16'h1234;
    tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_in_ready_low: got %0b want 0", in_ready); end
    in_valid = 1'b0; RST = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_out_valid: got %0b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_in_ready: got %0b want 1", in_ready); end
    checks++; if (sampleT !== 16'd0) begin errors++; $display("[TB] FAIL rst_sampleT: got %0h want 0", sampleT); end
    checks++; if (output_data !== 32'd0) begin errors++; $display("[TB] FAIL rst_output: got %0h want 0", output_data); end
    checks++; if (sat_flag !== 1'b0 || coef_rej !== 1'b0) begin errors++; $display("[TB] FAIL rst_flags: sat=%0b rej=%0b want 0 0", sat_flag, coef_rej); end
  endtask

  task automatic test_impulse();
    logic [31:0] y1; logic [15:0] y2; logic f1, f2; int lat, exp;
    do_reset();
    run_sample(100, y1, f1, y2, f2, lat);
    checks++; if (lat != 8) begin errors++; $display("[TB] FAIL impulse_latency: got %0d want 8", lat); end
    checks++; if (y1 !== 32'd1600 || f1 !== 1'b0) begin errors++; $display("[TB] FAIL impulse[0]: got %0d sat %0b want 1600 sat 0", $signed(y1), f1); end
    for (int i = 1; i <= 8; i++) begin
      run_sample(0, y1, f1, y2, f2, lat);
      exp = (i < 8) ? 1600 : 0;
      checks++; if (y1 !== 32'(exp)) begin errors++; $display("[TB] FAIL impulse[%0d]: got %0d want %0d", i, $signed(y1), exp); end
    end
  endtask

  task automatic test_step();
    logic [31:0] y1; logic [15:0] y2; logic f1, f2; int lat, exp;
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      run_sample(1000, y1, f1, y2, f2, lat);
      exp = ((i < 8) ? i : 8) * 16000;
      checks++; if (y1 !== 32'(exp)) begin errors++; $display("[TB] FAIL step[%0d]: got %0d want %0d", i, $signed(y1), exp); end
    end
  endtask

  task automatic test_coef();
    logic [31:0] y1; logic [15:0] y2; logic f1, f2; int lat, exp;
    do_reset();
    for (int a = 0; a < 8; a++) write_coef(a, (a == 0) ? 1 : 0);
    checks++; if (coef_rej !== 1'b0) begin errors++; $display("[TB] FAIL coef_rej_idle: got %0b want 0", coef_rej); end
    run_sample(123, y1, f1, y2, f2, lat);
    checks++; if (y1 !== 32'd123) begin errors++; $display("[TB] FAIL passthru_a: got %0d want 123", $signed(y1)); end
    run_sample(-456, y1, f1, y2, f2, lat);
    checks++; if (y1 !== 32'(-456)) begin errors++; $display("[TB] FAIL passthru_b: got %0d want -456", $signed(y1)); end
    do_reset();
    for (int a = 0; a < 8; a++) write_coef(a, (a == 7) ? -1 : 0);
    for (int i = 1; i <= 9; i++) begin
      run_sample(10 * i, y1, f1, y2, f2, lat);
      exp = (i >= 8) ? -10 * (i - 7) : 0;
      checks++; if (y1 !== 32'(exp)) begin errors++; $display("[TB] FAIL delay7[%0d]: got %0d want %0d", i, $signed(y1), exp); end
    end
  endtask

  task automatic test_hold();
    logic [31:0] y1, held; logic [15:0] y2; logic f1, f2; int lat, guard;
    do_reset();
    for (int a = 0; a < 8; a++) write_coef(a, (a < 3) ? a + 1 : 0);
    out_ready = 1'b0; input_data = 16'd5; in_valid = 1'b1;
    tick();
    input_data = 16'd7;
    guard = 0;
    while (!out_valid && guard < 50) begin tick(); guard++; end
    held = output_data;
    checks++; if (held !== 32'd5) begin errors++; $display("[TB] FAIL hold_first: got %0d want 5", $signed(held)); end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (output_data !== held || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL hold_stall[%0d]: data %0d valid %0b ready %0b want %0d 1 0", i, $signed(output_data), out_valid, in_ready, $signed(held));
      end
    end
    out_ready = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    guard = 0;
    while (!out_valid && guard < 50) begin tick(); guard++; end
    checks++; if (output_data !== 32'd17) begin errors++; $display("[TB] FAIL hold_second: got %0d want 17", $signed(output_data)); end
    tick();
    run_sample(0, y1, f1, y2, f2, lat);
    checks++; if (y1 !== 32'd29) begin errors++; $display("[TB] FAIL hold_history: got %0d want 29", $signed(y1)); end
  endtask

  task automatic test_enable();
    logic [31:0] y1; logic [15:0] y2; logic f1, f2; int lat;
    do_reset();
    ENABLE = 1'b0; in_valid = 1'b1; input_data = 16'd555;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL en_in_ready: got %0b want 0", in_ready); end
    write_coef(0, 0);
    checks++; if (coef_rej !== 1'b1) begin errors++; $display("[TB] FAIL en_coef_rej: got %0b want 1", coef_rej); end
    checks++; if (sampleT !== 16'd0) begin errors++; $display("[TB] FAIL en_no_accept: got %0d want 0", sampleT); end
    in_valid = 1'b0; ENABLE = 1'b1;
    tick();
    checks++; if (coef_rej !== 1'b0) begin errors++; $display("[TB] FAIL en_rej_pulse: got %0b want 0", coef_rej); end
    run_sample(100, y1, f1, y2, f2, lat);
    checks++; if (y1 !== 32'd1600) begin errors++; $display("[TB] FAIL en_coef_kept: got %0d want 1600", $signed(y1)); end
    input_data = 16'd0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    ENABLE = 1'b0;
    repeat (3) tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL en_freeze_valid: got %0b want 0", out_valid); end
    ENABLE = 1'b1;
    #1;
    lat = 0;
    while (!out_valid && lat < 50) begin tick(); lat++; end
    checks++; if (lat != 7) begin errors++; $display("[TB] FAIL en_freeze_latency: got %0d want 7", lat); end
    checks++; if (output_data !== 32'd1600) begin errors++; $display("[TB] FAIL en_freeze_result: got %0d want 1600", $signed(output_data)); end
    tick();
  endtask

  task automatic test_midmac();
    logic [31:0] y1; logic [15:0] y2; logic f1, f2; int lat, guard; logic seen;
    do_reset();
    input_data = 16'd100; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    write_coef(0, 0);
    checks++; if (coef_rej !== 1'b1) begin errors++; $display("[TB] FAIL mac_coef_rej: got %0b want 1", coef_rej); end
    tick();
    checks++; if (coef_rej !== 1'b0) begin errors++; $display("[TB] FAIL mac_rej_pulse: got %0b want 0", coef_rej); end
    guard = 0;
    while (!out_valid && guard < 50) begin tick(); guard++; end
    checks++; if (output_data !== 32'd1600) begin errors++; $display("[TB] FAIL mac_coef_kept: got %0d want 1600", $signed(output_data)); end
    tick();
    input_data = 16'd500; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    RST = 1'b0;
    tick();
    RST = 1'b1;
    seen = 1'b0;
    repeat (12) begin tick(); if (out_valid) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("[TB] FAIL mac_abort: out_valid seen %0b want 0", seen); end
    run_sample(100, y1, f1, y2, f2, lat);
    checks++; if (y1 !== 32'd1600) begin errors++; $display("[TB] FAIL mac_after_rst: got %0d want 1600", $signed(y1)); end
  endtask

  task automatic test_saturate();
    logic [31:0] y1; logic [15:0] y2; logic f1, f2; int lat;
    do_reset();
    for (int a = 0; a < 8; a++) write_coef(a, 127);
    for (int i = 0; i < 8; i++) run_sample(32767, y1, f1, y2, f2, lat);
    checks++; if (y2 !== 16'h7FFF || f2 !== 1'b1) begin errors++; $display("[TB] FAIL sat_pos16: got %0d sat %0b want 32767 sat 1", $signed(y2), f2); end
    checks++; if (y1 !== 32'd33291272 || f1 !== 1'b0) begin errors++; $display("[TB] FAIL sat_pos32: got %0d sat %0b want 33291272 sat 0", $signed(y1), f1); end
    for (int i = 0; i < 8; i++) run_sample(-32768, y1, f1, y2, f2, lat);
    checks++; if (y2 !== 16'h8000 || f2 !== 1'b1) begin errors++; $display("[TB] FAIL sat_neg16: got %0d sat %0b want -32768 sat 1", $signed(y2), f2); end
    checks++; if (y1 !== 32'(-33292288) || f1 !== 1'b0) begin errors++; $display("[TB] FAIL sat_neg32: got %0d sat %0b want -33292288 sat 0", $signed(y1), f1); end
    checks++; if (sampleT2 !== 16'h8000 || in_ready2 !== 1'b1 || out_valid2 !== 1'b0 || coef_rej2 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL sat_dut16_idle: sampleT %0h ready %0b valid %0b rej %0b want 8000 1 0 0", sampleT2, in_ready2, out_valid2, coef_rej2);
    end
  endtask

  initial begin
    $display("[TB] starting fir_mac_serial bench");
    test_reset();
    test_impulse();
    test_step();
    test_coef();
    test_hold();
    test_enable();
    test_midmac();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
